hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core (IFU/IDU/EXU/MEM/WB).
- Detects load-use hazards that forwarding cannot resolve.
- Holds the pipeline while a multi-cycle MULT/DIV occupies the HiLo unit, and releases the HiLo write exactly once on completion.
- Sits beside the stage registers and drives their per-stage stall and bubble controls.

---
 rtl/haz_pkg.sv | 30 +++
 rtl/md_seq.sv | 68 ++++++
 rtl/hazard_ctrl.sv | 90 +++++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/haz_pkg.sv
// Shared constants for the pipeline hazard controller: stage bit indices,
// multi-cycle sequencer state encoding and per-hazard stall patterns.
package haz_pkg;

  localparam int STG_IFU = 0;
  localparam int STG_IDU = 1;
  localparam int STG_EXU = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int NUM_STG = 5;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_BUSY = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  localparam logic [NUM_STG-1:0] STALL_NONE    = 5'b00000;
  localparam logic [NUM_STG-1:0] STALL_LOADUSE = 5'b00011;
  localparam logic [NUM_STG-1:0] STALL_MD      = 5'b00111;

  // One IDU source operand: read enable plus register number.
  typedef struct packed {
    logic       rd;
    logic [4:0] addr;
  } src_t;

  function automatic logic src_hit(input src_t src, input logic [4:0] dst);
    return src.rd && (src.addr == dst);
  endfunction

endpackage

// File: rtl/md_seq.sv
// MULT/DIV sequencer: busy is combinational in the start cycle and stays high for N cycles,
// done pulses for exactly one cycle afterwards; start is ignored outside IDLE.
module md_seq
  import haz_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MD_IDLE: begin
        if (start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_nxt = MD_DONE;
        end
      end
      // The op that just finished still sits in EXU, so a held start must not re-arm here.
      MD_DONE: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign busy = ((state == MD_IDLE) && start) || (state == MD_BUSY);
  assign done = (state == MD_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/bubble controller: load-use and MULT/DIV holds, combinational outputs, MEM/WB never held.
// Optional stall-cycle performance counter enabled by HAZ_PERF_CNT_EN.
module hazard_ctrl
  import haz_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         id_regaRd,
  input  logic [4:0]   id_regaAddr,
  input  logic         id_regbRd,
  input  logic [4:0]   id_regbAddr,
  input  logic         ex_memRr,
  input  logic         ex_regcWr,
  input  logic [4:0]   ex_regcAddr,
  input  logic         ex_md_start,
  input  logic         ex_md_is_div,
  output logic [4:0]   stall,
  output logic         ex_bubble,
  output logic         mem_bubble,
  output logic         md_busy,
  output logic         hilo_we_en,
  output logic [31:0]  perf_stall_cnt
);

  src_t src_a;
  src_t src_b;
  logic lu_hit;
  logic md_busy_raw;
  logic md_done_raw;

  assign src_a = '{rd: id_regaRd, addr: id_regaAddr};
  assign src_b = '{rd: id_regbRd, addr: id_regbAddr};

  // $0 is hardwired to zero, so a load "to" it never creates a dependency.
  assign lu_hit = ex_memRr && ex_regcWr && (ex_regcAddr != 5'd0) &&
                  (src_hit(src_a, ex_regcAddr) || src_hit(src_b, ex_regcAddr));

  md_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_seq (
    .clk    (clk),
    .resetn (resetn),
    .start  (ex_md_start),
    .is_div (ex_md_is_div),
    .busy   (md_busy_raw),
    .done   (md_done_raw)
  );

  // Outputs are forced low while reset is held so the stage registers see a quiet pipeline.
  always_comb begin
    stall      = STALL_NONE;
    ex_bubble  = 1'b0;
    mem_bubble = 1'b0;
    if (resetn) begin
      if (md_busy_raw) begin
        stall      = STALL_MD;
        mem_bubble = 1'b1;
      end else if (lu_hit) begin
        stall      = STALL_LOADUSE;
        ex_bubble  = 1'b1;
      end
    end
  end

  assign md_busy    = resetn && md_busy_raw;
  assign hilo_we_en = resetn && md_done_raw;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_q <= '0;
    end else if (stall[STG_IFU] && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a cycle-index reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        id_regaRd = 1'b0;
  logic [4:0]  id_regaAddr = 5'd0;
  logic        id_regbRd = 1'b0;
  logic [4:0]  id_regbAddr = 5'd0;
  logic        ex_memRr = 1'b0;
  logic        ex_regcWr = 1'b0;
  logic [4:0]  ex_regcAddr = 5'd0;
  logic        ex_md_start = 1'b0;
  logic        ex_md_is_div = 1'b0;
  logic [4:0]  stall;
  logic        ex_bubble;
  logic        mem_bubble;
  logic        md_busy;
  logic        hilo_we_en;
  logic [31:0] perf_stall_cnt;

  localparam int N_MULT = 4;
  localparam int N_DIV  = 32;

  hazard_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .id_regaRd      (id_regaRd),
    .id_regaAddr    (id_regaAddr),
    .id_regbRd      (id_regbRd),
    .id_regbAddr    (id_regbAddr),
    .ex_memRr       (ex_memRr),
    .ex_regcWr      (ex_regcWr),
    .ex_regcAddr    (ex_regcAddr),
    .ex_md_start    (ex_md_start),
    .ex_md_is_div   (ex_md_is_div),
    .stall          (stall),
    .ex_bubble      (ex_bubble),
    .mem_bubble     (mem_bubble),
    .md_busy        (md_busy),
    .hilo_we_en     (hilo_we_en),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: an op is a window of cycle indices [t, t+N-1] busy, t+N done.
  int  cyc = 0;
  bit  m_active = 0;
  int  m_t = 0;
  int  m_n = 0;
  longint m_perf = 0;

  // Scenario tallies observed on the DUT, compared against fixed expectations.
  int  md_cyc_seen = 0;
  int  hilo_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic rn, input logic ard, input logic [4:0] aa,
                      input logic brd, input logic [4:0] ba, input logic mr,
                      input logic wr, input logic [4:0] ca, input logic st,
                      input logic dv);
    logic       hit;
    logic       mbusy;
    logic       mdone;
    logic [4:0] es;
    logic [31:0] eperf;
    @(posedge clk);
    #1;
    resetn       = rn;
    id_regaRd    = ard;
    id_regaAddr  = aa;
    id_regbRd    = brd;
    id_regbAddr  = ba;
    ex_memRr     = mr;
    ex_regcWr    = wr;
    ex_regcAddr  = ca;
    ex_md_start  = st;
    ex_md_is_div = dv;
    @(negedge clk);
    if (!rn) begin
      m_active = 0;
      m_perf   = 0;
    end else if (!m_active && st) begin
      m_active = 1;
      m_t      = cyc;
      m_n      = dv ? N_DIV : N_MULT;
    end
    mbusy = rn && m_active && (cyc < m_t + m_n);
    mdone = rn && m_active && (cyc == m_t + m_n);
    hit   = rn && mr && wr && (ca != 5'd0) && ((ard && aa == ca) || (brd && ba == ca));
    es    = mbusy ? 5'b00111 : (hit ? 5'b00011 : 5'b00000);
`ifdef HAZ_PERF_CNT_EN
    eperf = (m_perf > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_perf);
`else
    eperf = 32'd0;
`endif
    chk("stall",      32'(stall),      32'(es));
    chk("ex_bubble",  32'(ex_bubble),  32'(hit && !mbusy));
    chk("mem_bubble", 32'(mem_bubble), 32'(mbusy));
    chk("md_busy",    32'(md_busy),    32'(mbusy));
    chk("hilo_we_en", 32'(hilo_we_en), 32'(mdone));
    chk("perf",       perf_stall_cnt,  eperf);
    if (stall == 5'b00111) md_cyc_seen++;
    if (hilo_we_en) hilo_seen++;
    if (mdone) m_active = 0;
    if (rn && es[0]) m_perf++;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic in_reset(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 5'd8, 0, 0, 1, 1, 5'd8, 1, 0);
  endtask

  task automatic load_use(input int which, input logic [4:0] r, input logic st);
    if (which == 0) step(1, 1, r, 0, 0, 1, 1, r, st, 0);
    else            step(1, 0, 0, 1, r, 1, 1, r, st, 0);
  endtask

  initial begin
    // Reset with hazard-looking inputs: everything must stay low.
    in_reset(3);
    idle(2);

    // Load-use on operand A and B, then $0, then non-load and mismatched register.
    load_use(0, 5'd8, 0);
    idle(1);
    load_use(1, 5'd17, 0);
    idle(1);
    load_use(0, 5'd0, 0);
    step(1, 1, 5'd8, 0, 0, 0, 1, 5'd8, 0, 0);
    step(1, 1, 5'd9, 1, 5'd7, 1, 1, 5'd8, 0, 0);
    idle(1);

    // MULT with start held through DONE.
    md_cyc_seen = 0;
    hilo_seen   = 0;
    for (int i = 0; i <= N_MULT; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);
    chk("mult_stall_cycles", 32'(md_cyc_seen), 32'd4);
    chk("mult_hilo_pulses",  32'(hilo_seen),   32'd1);

    // DIV with start held through DONE.
    md_cyc_seen = 0;
    hilo_seen   = 0;
    for (int i = 0; i <= N_DIV; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);
    chk("div_stall_cycles", 32'(md_cyc_seen), 32'd32);
    chk("div_hilo_pulses",  32'(hilo_seen),   32'd1);

    // Collision: load-use during BUSY is masked, load-use at DONE is serviced.
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    load_use(0, 5'd5, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    load_use(1, 5'd5, 1);
    idle(2);

    // Perf: fresh reset, one MULT plus one load-use gives five stalled IFU cycles.
    in_reset(1);
    for (int i = 0; i <= N_MULT; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    load_use(0, 5'd12, 0);
    idle(2);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_mult_plus_lu", perf_stall_cnt, 32'd5);
`else
    chk("perf_disabled", perf_stall_cnt, 32'd0);
`endif

    // Reset mid-BUSY aborts the op; no HiLo pulse may follow.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    in_reset(2);
    hilo_seen = 0;
    idle(40);
    chk("abort_no_hilo", 32'(hilo_seen), 32'd0);

    // Random traffic on a small register set to provoke frequent hits.
    for (int i = 0; i < 1500; i++) begin
      logic [4:0] ra, rb, rc;
      ra = 5'($urandom_range(0, 3));
      rb = 5'($urandom_range(0, 3));
      rc = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 199) != 0),
           1'($urandom), ra, 1'($urandom), rb,
           1'($urandom), 1'($urandom), rc,
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0));
    end
    idle(40);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
